// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller slice:
// FSM state encoding, default parameter values and the ID width helper.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE,
      RETURN
   } irq_state_e;

   // Default number of request lines.
   localparam int DEF_NUM_SRC = 8;

   // Idle cycles after mret before a new request may be raised; long enough
   // to cover the core's return sequence without padding it with NOPs.
   localparam int DEF_RET_GAP = 3;

   // Width of a source index; never narrower than one bit.
   function automatic int irq_id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller and the core-side logic.
// The slave modport is the controller; the master modport is the core side
// (request sources, mask writer, trap claim/return pulses).
interface interrupt_controller_if
   import irq_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC
) ();

   localparam int ID_W = irq_id_width(NUM_SRC);

   logic [NUM_SRC-1:0] SRC_IRQ;
   logic               MASK_WE;
   logic [NUM_SRC-1:0] MASK_WDATA;
   logic               IRQ_ACK;
   logic               MRET;
   logic               INTERRUPT;
   logic [ID_W-1:0]    IRQ_ID;
   logic               IRQ_ACTIVE;
   logic [NUM_SRC-1:0] PENDING;

   modport master (
      output SRC_IRQ,
      output MASK_WE,
      output MASK_WDATA,
      output IRQ_ACK,
      output MRET,
      input  INTERRUPT,
      input  IRQ_ID,
      input  IRQ_ACTIVE,
      input  PENDING
   );

   modport slave (
      input  SRC_IRQ,
      input  MASK_WE,
      input  MASK_WDATA,
      input  IRQ_ACK,
      input  MRET,
      output INTERRUPT,
      output IRQ_ID,
      output IRQ_ACTIVE,
      output PENDING
   );

endinterface

// File: rtl/interrupt_controller_arbiter.sv
// Combinational find-first-set with a rotating start index.
// A start of 0 gives fixed lowest-index priority; feeding last_claimed+1
// gives round-robin. The search wraps from NUM_SRC-1 back to 0.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int ID_W    = irq_id_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    start,
   output logic               valid,
   output logic [ID_W-1:0]    id
);

   // One extra bit so start + offset cannot overflow before the wrap.
   localparam int IDX_W = ID_W + 1;

   logic [IDX_W-1:0] idx;

   // Scan all sources starting at 'start'; the first set request wins.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
      valid = 1'b0;
      id    = '0;
      idx   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = {1'b0, start} + IDX_W'(i);
         if (idx >= IDX_W'(NUM_SRC)) begin
            idx = idx - IDX_W'(NUM_SRC);
         end
         if (!valid && req[idx[ID_W-1:0]]) begin
            valid = 1'b1;
            id    = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: source side of the core's single INTERRUPT input.
// Synchronizes and edge-detects NUM_SRC request lines into pending bits,
// masks them, arbitrates, presents one request and tracks the trap through
// claim (IRQ_ACK) and return (MRET), holding off new requests for RET_GAP
// cycles after mret.
// Optional feature: define IRQ_ROUND_ROBIN_EN for round-robin arbitration
// starting after the last claimed source; otherwise the lowest eligible
// index wins.
module interrupt_controller
   import irq_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int RET_GAP = DEF_RET_GAP
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   interrupt_controller_if.slave  bus
);

   localparam int ID_W  = irq_id_width(NUM_SRC);
   localparam int CNT_W = (RET_GAP > 1) ? $clog2(RET_GAP) : 1;

   logic [NUM_SRC-1:0] sync1;
   logic [NUM_SRC-1:0] sync2;
   logic [NUM_SRC-1:0] edge_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr;

   irq_state_e         state;
   logic [ID_W-1:0]    irq_id;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    start_id;
   logic               win_valid;
   logic               interrupt;
   logic               irq_active;
   logic [CNT_W-1:0]   gap_cnt;
   logic               claim;

   assign rise     = sync2 & ~edge_q;
   assign eligible = pending & mask;
   assign claim    = (state == REQ) && bus.IRQ_ACK;

   // Two-flop synchronizer followed by the edge register that remembers the previous level.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync1  <= '0;
         sync2  <= '0;
         edge_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sync1  <= bus.SRC_IRQ;
         sync2  <= sync1;
         edge_q <= sync2;
      end
   end

   // One-hot clear for the source being claimed this cycle.
   always_comb begin
      clr = '0;
      if (claim) begin
         clr[irq_id] = 1'b1;
      end
   end

   // Pending bits (set beats clear in the same cycle) and the enable mask.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         pending <= (pending & ~clr) | rise;
         if (bus.MASK_WE) begin
            mask <= bus.MASK_WDATA;
         end
      end
   end

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_claimed;

   // Remember the most recently claimed source so the search starts just after it.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         last_claimed <= ID_W'(NUM_SRC - 1);
      end else if (claim) begin
         last_claimed <= irq_id;
      end
   end

   assign start_id = (last_claimed == ID_W'(NUM_SRC - 1)) ? '0 : last_claimed + 1'b1;
`else
   assign start_id = '0;
`endif

   irq_arbiter #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_arbiter (
      .req   (eligible),
      .start (start_id),
      .valid (win_valid),
      .id    (win_id)
   );

   // Trap-tracking FSM with registered INTERRUPT / IRQ_ACTIVE / IRQ_ID and the post-mret gap counter.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         irq_id     <= '0;
         interrupt  <= 1'b0;
         irq_active <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  irq_id    <= win_id;
                  interrupt <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               // A claim takes precedence over the source being masked off.
               if (bus.IRQ_ACK) begin
                  interrupt  <= 1'b0;
                  irq_active <= 1'b1;
                  state      <= SERVICE;
               end else if (!mask[irq_id]) begin
                  interrupt <= 1'b0;
                  state     <= IDLE;
               end
            end
            SERVICE: begin
               if (bus.MRET) begin
                  irq_active <= 1'b0;
                  gap_cnt    <= CNT_W'(RET_GAP - 1);
                  state      <= RETURN;
               end
            end
            RETURN: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               interrupt  <= 1'b0;
               irq_active <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.INTERRUPT  = interrupt;
   assign bus.IRQ_ID     = irq_id;
   assign bus.IRQ_ACTIVE = irq_active;
   assign bus.PENDING    = pending;

endmodule
